extbus_arb: RTL
===============

EXTBUS_ARB -- requirements
Module: extbus_arb

Interface
REQ-001 Parameter SETUP, default 1, number of cycles port X address/enable is held stable before the transfer cycle; legal range 1..4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous reset, active high (one clock; reset is synchronous and active-high).
REQ-004 req  input  3  per-requester transaction request, level, held until matching ack.
REQ-005 req_addr  input  6  word address per requester; requester i at bits [2i+1:2i].
REQ-006 req_wr  input  3  per-requester direction: 1 = write into bank, 0 = read from bank.
REQ-007 gnt  output  3  one-hot grant, asserted for the whole transaction.
REQ-008 ack  output  3  one-cycle completion pulse to the granted requester.
REQ-009 AX  output  2  port X word address to the exchange register bank.
REQ-010 ECX  output  1  port X enable, active high.
REQ-011 WX  output  1  port X write strobe, active high.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement FSM states IDLE, SETUP, XFER, DONE.
REQ-014 IDLE: if any req bit is set, the block SHALL select one winner, latch its address and direction, set gnt to the winner and go to SETUP; otherwise stay in IDLE.
REQ-015 SETUP: ECX=1, AX=latched address, WX=0 for exactly SETUP cycles, then XFER.
REQ-016 XFER: one cycle, ECX=1, AX=latched address, WX=latched direction; read data on the bank's port X output is valid in this cycle.
REQ-017 DONE: one cycle, ECX=0, WX=0, ack of winner=1, gnt held; next state IDLE.
REQ-018 gnt SHALL clear on entry to IDLE; ack and WX SHALL never be high outside DONE and XFER respectively.
REQ-019 Latency: req sampled in IDLE at cycle 0, ack asserted at cycle SETUP+2; back-to-back transactions SHALL be separated by exactly one IDLE cycle.
REQ-020 AX and latched direction SHALL stay constant from SETUP through DONE regardless of req_addr/req_wr changes.
REQ-021 A requester dropping req mid-transaction SHALL NOT abort it; ack is still pulsed.
REQ-022 Requests arriving while busy SHALL wait; arbitration occurs only in IDLE.
REQ-023 gnt SHALL always be zero or one-hot; at most one ack bit high in any cycle.
REQ-024 Arbitration order is set by REQ-029/REQ-030.

Reset
REQ-025 While reset is high at a clock edge the FSM SHALL go to IDLE and gnt, ack, AX, ECX, WX, busy SHALL all be 0 the following cycle.
REQ-026 Reset during SETUP, XFER or DONE SHALL abort the transaction without an ack pulse.
REQ-027 Reset SHALL set the round-robin last-grant pointer to requester 2.

Configuration
REQ-028 Macro EXTBUS_ARB_RR_EN selects the arbitration policy.
REQ-029 With EXTBUS_ARB_RR_EN defined: round robin; search starts at last-granted index +1 modulo 3; pointer updates on each grant.
REQ-030 Without EXTBUS_ARB_RR_EN: fixed priority, requester 0 highest, 2 lowest; no pointer state.

Verification
REQ-031 SETUP=1, reset, req=001, req_addr[1:0]=2, req_wr=1 -> gnt=001 in cycles 1-3, AX=2 and ECX=1 in cycles 1-2, WX=1 only cycle 2, ack=001 cycle 3.
REQ-032 SETUP=3, read req on requester 1 addr 3 -> ECX=1 cycles 1-4, WX=0 throughout, ack=010 at cycle 5.
REQ-033 RR_EN defined, req=111 held -> grant order 0,1,2,0, each ack 4 cycles apart (SETUP=1); RR_EN undefined -> grants 0,0,0.
REQ-034 req_addr changed 0->3 during SETUP -> AX remains 0 through DONE.
REQ-035 reset asserted in XFER -> next cycle all outputs 0, no ack; new req=100 then served normally.
REQ-036 requester drops req in SETUP -> transaction completes, ack pulsed at cycle SETUP+2, FSM returns IDLE.

Source files
------------

// File: rtl/extbus_arb.sv
// extbus_arb: three-requester arbiter driving port X of the exchange register bank.
// Define EXTBUS_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module extbus_arb #(
    parameter int SETUP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [5:0] req_addr,
    input  logic [2:0] req_wr,
    output logic [2:0] gnt,
    output logic [2:0] ack,
    output logic [1:0] AX,
    output logic       ECX,
    output logic       WX,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_DONE
    } state_t;

    localparam logic [1:0] SETUP_LAST = 2'(SETUP - 1);

    state_t     state;
    logic [1:0] cnt;
    logic       dir;
    logic [1:0] win;
    logic [1:0] win_addr;
    logic       win_wr;

`ifdef EXTBUS_ARB_RR_EN
    logic [1:0] last;

    // search begins one past the most recent winner
    always_comb begin
        win = 2'd0;
        unique case (last)
            2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end
`else
    always_comb begin
        win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    end
`endif

    always_comb begin
        win_addr = req_addr[1:0];
        win_wr   = req_wr[0];
        unique case (win)
            2'd1: begin
                win_addr = req_addr[3:2];
                win_wr   = req_wr[1];
            end
            2'd2: begin
                win_addr = req_addr[5:4];
                win_wr   = req_wr[2];
            end
            default: begin
                win_addr = req_addr[1:0];
                win_wr   = req_wr[0];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
            dir   <= 1'b0;
            gnt   <= 3'b000;
            ack   <= 3'b000;
            AX    <= 2'd0;
            ECX   <= 1'b0;
            WX    <= 1'b0;
            busy  <= 1'b0;
`ifdef EXTBUS_ARB_RR_EN
            last  <= 2'd2;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state <= ST_SETUP;
                        cnt   <= 2'd0;
                        dir   <= win_wr;
                        gnt   <= 3'b001 << win;
                        AX    <= win_addr;
                        ECX   <= 1'b1;
                        busy  <= 1'b1;
`ifdef EXTBUS_ARB_RR_EN
                        last  <= win;
`endif
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state <= ST_XFER;
                        WX    <= dir;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                ST_XFER: begin
                    state <= ST_DONE;
                    ECX   <= 1'b0;
                    WX    <= 1'b0;
                    ack   <= gnt;
                end
                default: begin
                    state <= ST_IDLE;
                    ack   <= 3'b000;
                    gnt   <= 3'b000;
                    AX    <= 2'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
